key_event_decoder: RTL and testbench

//  Parametrised N-channel PS/2 scan-code event decoder between the keyboard module (heldData)
//  and game control FSMs. Each channel maps one scan code to one of four modes: level,

---
 rtl/key_event_decoder.sv | 142 ++++++++++++++
 tb/tb_key_event_decoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// PS/2 scan-code event decoder: per-channel level / pulse / toggle-on-release / auto-repeat
// events from the currently held scan code, gated by per-channel enables.
module key_event_decoder #(
  parameter int                     NUM_KEYS        = 8,
  parameter int                     CLOCK_FREQUENCY = 25000000,
  parameter logic [8*NUM_KEYS-1:0]  KEY_CODES       = 64'h25261E16595A7629,
  parameter logic [2*NUM_KEYS-1:0]  KEY_MODES       = '0,
  parameter int                     REPEAT_DELAY_MS = 400,
  parameter int                     REPEAT_RATE_MS  = 100
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic [7:0]          kbData,
  input  logic [NUM_KEYS-1:0] enable,
  input  logic [NUM_KEYS-1:0] clear_toggle,
  output logic [NUM_KEYS-1:0] event_out,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] toggle_state,
  output logic                any_key
);

  // state     | meaning
  // RPT_IDLE  | repeat channel waiting for a press
  // RPT_DELAY | pressed, waiting out the initial repeat delay
  // RPT_RATE  | auto-repeating at the repeat rate

  localparam longint DELAY_TICKS = longint'(REPEAT_DELAY_MS) * longint'(CLOCK_FREQUENCY) / longint'(1000);
  localparam longint RATE_TICKS  = longint'(REPEAT_RATE_MS)  * longint'(CLOCK_FREQUENCY) / longint'(1000);
  localparam longint DELAY_CNT   = (DELAY_TICKS > 0) ? DELAY_TICKS - 1 : 0;
  localparam longint RATE_CNT    = (RATE_TICKS  > 0) ? RATE_TICKS  - 1 : 0;
  localparam longint MAX_CNT     = (DELAY_CNT > RATE_CNT) ? DELAY_CNT : RATE_CNT;
  localparam int     TIMER_W     = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;

  localparam logic [TIMER_W-1:0] DELAY_LOAD = DELAY_CNT[TIMER_W-1:0];
  localparam logic [TIMER_W-1:0] RATE_LOAD  = RATE_CNT[TIMER_W-1:0];

  localparam logic [1:0] MODE_LEVEL  = 2'd0;
  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_RATE} rpt_state_t;

  rpt_state_t          rpt_state [NUM_KEYS];
  rpt_state_t          rpt_next  [NUM_KEYS];
  logic [TIMER_W-1:0]  timer, timer_next;
  logic [NUM_KEYS-1:0] match, press, rel;
  logic [NUM_KEYS-1:0] arm, arm_next, toggle_next, event_next;
  logic                load_delay, load_rate, clear_timer;

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++)
      match[i] = (kbData == KEY_CODES[8*i +: 8]) && (kbData != 8'h00);
  end

  assign press = match & ~held;
  assign rel   = ~match & held;

  always_comb begin
    event_next  = '0;
    arm_next    = arm;
    toggle_next = toggle_state;
    load_delay  = 1'b0;
    load_rate   = 1'b0;
    clear_timer = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      rpt_next[i] = rpt_state[i];
      case (KEY_MODES[2*i +: 2])
        MODE_LEVEL: event_next[i] = match[i] & enable[i];
        MODE_PULSE: event_next[i] = press[i] & enable[i];
        MODE_TOGGLE: begin
          // release is honoured without enable so a key armed in one control state
          // still takes effect when released after the enables have changed
          if (clear_toggle[i]) begin
            arm_next[i]    = 1'b0;
            toggle_next[i] = 1'b0;
          end else if (rel[i] && arm[i]) begin
            arm_next[i]    = 1'b0;
            toggle_next[i] = ~toggle_state[i];
            event_next[i]  = 1'b1;
          end else if (press[i] && enable[i]) begin
            arm_next[i] = 1'b1;
          end
        end
        default: begin
          case (rpt_state[i])
            RPT_IDLE: begin
              if (press[i] && enable[i]) begin
                event_next[i] = 1'b1;
                rpt_next[i]   = RPT_DELAY;
                load_delay    = 1'b1;
              end
            end
            default: begin
              if (!match[i] || !enable[i]) begin
                rpt_next[i] = RPT_IDLE;
                clear_timer = 1'b1;
              end else if (timer == '0) begin
                event_next[i] = 1'b1;
                rpt_next[i]   = RPT_RATE;
                load_rate     = 1'b1;
              end
            end
          endcase
        end
      endcase
    end
    // loads win over a clear so a direct A->B change between repeat keys restarts cleanly
    if (load_delay)
      timer_next = DELAY_LOAD;
    else if (load_rate)
      timer_next = RATE_LOAD;
    else if (clear_timer)
      timer_next = '0;
    else if (timer != '0)
      timer_next = timer - 1'b1;
    else
      timer_next = timer;
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      event_out    <= '0;
      held         <= '0;
      toggle_state <= '0;
      arm          <= '0;
      any_key      <= 1'b0;
      timer        <= '0;
      for (int i = 0; i < NUM_KEYS; i++)
        rpt_state[i] <= RPT_IDLE;
    end else begin
      event_out    <= event_next;
      held         <= match;
      toggle_state <= toggle_next;
      arm          <= arm_next;
      any_key      <= (kbData != 8'h00);
      timer        <= timer_next;
      for (int i = 0; i < NUM_KEYS; i++)
        rpt_state[i] <= rpt_next[i];
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: ch0 PULSE 29, ch1 TOGGLE 76, ch2 REPEAT 5A,
// ch4 LEVEL duplicate of 29; 1 kHz clock so repeat delay = 4 cycles, rate = 2 cycles.
module tb_key_event_decoder;

  localparam int NK = 8;

  logic          Clock = 1'b0;
  logic          reset;
  logic [7:0]    kbData;
  logic [NK-1:0] enable, clear_toggle;
  logic [NK-1:0] event_out, held, toggle_state;
  logic          any_key;

  int n_pass = 0;
  int n_checks = 0;

  key_event_decoder #(
    .NUM_KEYS(NK),
    .CLOCK_FREQUENCY(1000),
    .KEY_CODES(64'h25261E29595A7629),
    .KEY_MODES(16'h0039),
    .REPEAT_DELAY_MS(4),
    .REPEAT_RATE_MS(2)
  ) dut (
    .Clock(Clock),
    .reset(reset),
    .kbData(kbData),
    .enable(enable),
    .clear_toggle(clear_toggle),
    .event_out(event_out),
    .held(held),
    .toggle_state(toggle_state),
    .any_key(any_key)
  );

  always #5 Clock = ~Clock;

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  int        ev0, ev4, h0, evany;
  logic [15:0] pmask;

  initial begin
    reset = 1'b0; kbData = 8'h29; enable = '1; clear_toggle = '0;
    repeat (3) cyc();
    check("rst_event", event_out, 0);
    check("rst_held", held, 0);
    check("rst_toggle", toggle_state, 0);
    check("rst_any", any_key, 0);

    reset = 1'b1; kbData = 8'h00;
    cyc();
    check("idle_event", event_out, 0);

    // PULSE ch0 with LEVEL duplicate on ch4
    kbData = 8'h29;
    ev0 = 0; ev4 = 0; h0 = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 0) check("pulse_first", event_out, 32'h11);
      if (k == 0) check("pulse_any", any_key, 1);
      ev0 += int'(event_out[0]);
      ev4 += int'(event_out[4]);
      h0  += int'(held[0]);
    end
    check("pulse_count", ev0, 1);
    check("pulse_held", h0, 10);
    check("dup_level", ev4, 10);
    kbData = 8'h00; cyc();
    check("pulse_rel_held", held, 0);
    check("pulse_rel_event", event_out, 0);

    // TOGGLE ch1: arm with enable, release without enable
    kbData = 8'h76; cyc();
    check("tog_press_noev", event_out, 0);
    enable = '0; kbData = 8'h00; cyc();
    check("tog_rel_event", event_out, 32'h02);
    check("tog_state1", toggle_state, 32'h02);
    cyc();
    check("tog_pulse_end", event_out, 0);
    enable = '1; kbData = 8'h76; cyc();
    kbData = 8'h00; cyc();
    check("tog_rel2_event", event_out, 32'h02);
    check("tog_state0", toggle_state, 0);
    enable = '0; kbData = 8'h76; cyc();
    kbData = 8'h00; cyc();
    check("tog_noarm_event", event_out, 0);
    check("tog_noarm_state", toggle_state, 0);
    enable = '1;

    // REPEAT ch2: pulses at cycles 1,5,7,9,11
    kbData = 8'h5A; pmask = '0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      pmask[k] = event_out[2];
    end
    check("rpt_pattern", pmask, 16'h0AA2);
    kbData = 8'h00; evany = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      evany += int'(|event_out);
    end
    check("rpt_release_silent", evany, 0);

    // direct change 29 -> 5A
    kbData = 8'h29; cyc();
    check("chg_held_a", held, 32'h11);
    kbData = 8'h5A; cyc();
    check("chg_held_b", held, 32'h04);
    check("chg_event_b", event_out, 32'h04);
    kbData = 8'h00; cyc();

    // clear_toggle beats an armed release
    kbData = 8'h76; cyc();
    kbData = 8'h00; cyc();
    check("clr_pre_state", toggle_state, 32'h02);
    kbData = 8'h76; cyc();
    kbData = 8'h00; clear_toggle = 8'h02; cyc();
    check("clr_event", event_out, 0);
    check("clr_state", toggle_state, 0);
    clear_toggle = '0;
    enable = '0; kbData = 8'h76; cyc();
    kbData = 8'h00; cyc();
    check("clr_arm_gone", event_out, 0);
    enable = '1;

    // reset while a toggle channel is armed and set
    kbData = 8'h76; cyc();
    kbData = 8'h00; cyc();
    kbData = 8'h76; cyc();
    reset = 1'b0; cyc(); cyc();
    check("mrst_toggle", toggle_state, 0);
    check("mrst_held", held, 0);
    reset = 1'b1; enable = '0; cyc();
    check("mrst_held_again", held, 32'h02);
    kbData = 8'h00; cyc();
    check("mrst_rel_event", event_out, 0);
    enable = '1;

    // reset mid-repeat
    kbData = 8'h5A; cyc();
    check("mrpt_first", event_out, 32'h04);
    cyc(); cyc();
    reset = 1'b0; kbData = 8'h00; cyc(); cyc();
    check("mrpt_rst_event", event_out, 0);
    reset = 1'b1; evany = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      evany += int'(|event_out);
    end
    check("mrpt_silent", evany, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
